// File: rtl/pc_unit_pkg.sv
// Shared definitions for the PC unit: default vectors and FSM state encodings.
package pc_unit_pkg;

    localparam int          PC_DATA_WIDTH = 32;
    localparam logic [31:0] PC_RESET_ADDR = 32'h0000_0000;
    localparam logic [31:0] PC_TRAP_ADDR  = 32'h0000_0100;
    localparam int          PC_INC        = 4;
    localparam int          PC_ALIGN_BITS = 2;

    typedef enum logic [1:0] {
        PC_ST_BOOT = 2'b00,
        PC_ST_RUN  = 2'b01,
        PC_ST_HALT = 2'b10
    } pc_state_e;

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC selection: redirect priority, jalr bit-0 clear and
// misaligned-target detection. Only trap, jump, branch, halt and stall matter here.
module pc_next_sel
    import pc_unit_pkg::*;
#(
    parameter int                    DATA_WIDTH = PC_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] TRAP_ADDR  = PC_TRAP_ADDR,
    parameter int                    ALIGN_BITS = PC_ALIGN_BITS
) (
    input  logic [DATA_WIDTH-1:0] i_pc,
    input  logic [DATA_WIDTH-1:0] i_pc_plus_inc,
    input  logic                  i_stall,
    input  logic                  i_halt,
    input  logic                  i_branch_taken,
    input  logic [DATA_WIDTH-1:0] i_branch_target,
    input  logic                  i_jump_en,
    input  logic [DATA_WIDTH-1:0] i_jump_target,
    input  logic                  i_trap,
    output logic [DATA_WIDTH-1:0] o_next_pc,
    output logic                  o_load_epc,
    output logic [DATA_WIDTH-1:0] o_epc_val,
    output logic                  o_mis_flag,
    output logic                  o_redirect
);

    localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = DATA_WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);
    localparam logic [DATA_WIDTH-1:0] BIT0_CLR   = ~DATA_WIDTH'(1);

    logic [DATA_WIDTH-1:0] w_target;
    logic                  w_target_bad;

    assign w_target     = i_jump_en ? (i_jump_target & BIT0_CLR) : i_branch_target;
    assign w_target_bad = |(w_target & ALIGN_MASK);

    always_comb begin
        o_next_pc  = i_pc_plus_inc;
        o_load_epc = 1'b0;
        o_epc_val  = i_pc;
        o_mis_flag = 1'b0;
        o_redirect = 1'b0;
        if (i_trap) begin
            o_next_pc  = TRAP_ADDR;
            o_load_epc = 1'b1;
            o_epc_val  = i_pc;
            o_redirect = 1'b1;
        end else if (i_jump_en || i_branch_taken) begin
            o_redirect = 1'b1;
            if (w_target_bad) begin
                // A bad target vectors to the trap handler and reports the target itself.
                o_next_pc  = TRAP_ADDR;
                o_load_epc = 1'b1;
                o_epc_val  = w_target;
                o_mis_flag = 1'b1;
            end else begin
                o_next_pc = w_target;
            end
        end else if (i_halt || i_stall) begin
            o_next_pc = i_pc;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Fetch PC register with BOOT/RUN/HALT sequencing, exception PC capture and a
// one-cycle misaligned-redirect pulse. Next-PC selection lives in pc_next_sel.
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int                    DATA_WIDTH = PC_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] RESET_ADDR = PC_RESET_ADDR,
    parameter logic [DATA_WIDTH-1:0] TRAP_ADDR  = PC_TRAP_ADDR,
    parameter int                    INC        = PC_INC,
    parameter int                    ALIGN_BITS = PC_ALIGN_BITS
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_stall,
    input  logic                  i_halt,
    input  logic                  i_resume,
    input  logic                  i_branch_taken,
    input  logic [DATA_WIDTH-1:0] i_branch_target,
    input  logic                  i_jump_en,
    input  logic [DATA_WIDTH-1:0] i_jump_target,
    input  logic                  i_trap,
    output logic [DATA_WIDTH-1:0] o_pc,
    output logic [DATA_WIDTH-1:0] o_pc_plus_inc,
    output logic [DATA_WIDTH-1:0] o_epc,
    output logic                  o_fetch_valid,
    output logic                  o_misaligned,
    output logic [1:0]            o_state
);

    pc_state_e             r_state;
    logic [DATA_WIDTH-1:0] r_pc;
    logic [DATA_WIDTH-1:0] r_epc;
    logic                  r_fetch_valid;
    logic                  r_misaligned;

    logic [DATA_WIDTH-1:0] w_pc_plus_inc;
    logic [DATA_WIDTH-1:0] w_next_pc;
    logic                  w_load_epc;
    logic [DATA_WIDTH-1:0] w_epc_val;
    logic                  w_mis_flag;
    logic                  w_redirect;

    // Natural truncation gives the silent wrap from the top of the address space.
    assign w_pc_plus_inc = r_pc + DATA_WIDTH'(INC);

    pc_next_sel #(
        .DATA_WIDTH (DATA_WIDTH),
        .TRAP_ADDR  (TRAP_ADDR),
        .ALIGN_BITS (ALIGN_BITS)
    ) u_next_sel (
        .i_pc            (r_pc),
        .i_pc_plus_inc   (w_pc_plus_inc),
        .i_stall         (i_stall),
        .i_halt          (i_halt),
        .i_branch_taken  (i_branch_taken),
        .i_branch_target (i_branch_target),
        .i_jump_en       (i_jump_en),
        .i_jump_target   (i_jump_target),
        .i_trap          (i_trap),
        .o_next_pc       (w_next_pc),
        .o_load_epc      (w_load_epc),
        .o_epc_val       (w_epc_val),
        .o_mis_flag      (w_mis_flag),
        .o_redirect      (w_redirect)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state       <= PC_ST_BOOT;
            r_pc          <= RESET_ADDR;
            r_epc         <= '0;
            r_fetch_valid <= 1'b0;
            r_misaligned  <= 1'b0;
        end else begin
            r_misaligned <= 1'b0;
            case (r_state)
                PC_ST_BOOT: begin
                    r_state       <= PC_ST_RUN;
                    r_fetch_valid <= 1'b1;
                end
                PC_ST_RUN: begin
                    r_pc         <= w_next_pc;
                    r_misaligned <= w_mis_flag;
                    if (w_load_epc) begin
                        r_epc <= w_epc_val;
                    end
                    if (!w_redirect && i_halt) begin
                        r_state       <= PC_ST_HALT;
                        r_fetch_valid <= 1'b0;
                    end
                end
                PC_ST_HALT: begin
                    // Trap outranks resume; redirects other than trap are ignored while halted.
                    if (i_trap) begin
                        r_pc          <= w_next_pc;
                        r_epc         <= w_epc_val;
                        r_state       <= PC_ST_RUN;
                        r_fetch_valid <= 1'b1;
                    end else if (i_resume) begin
                        r_state       <= PC_ST_RUN;
                        r_fetch_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state       <= PC_ST_BOOT;
                    r_fetch_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_pc          = r_pc;
    assign o_pc_plus_inc = w_pc_plus_inc;
    assign o_epc         = r_epc;
    assign o_fetch_valid = r_fetch_valid;
    assign o_misaligned  = r_misaligned;
    assign o_state       = r_state;

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: directed scenarios plus random stimulus against a
// behavioural next-PC model; a negedge monitor pops and compares expected outputs.
module tb_pc_unit;

    localparam logic [31:0] TRAP = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, halt, resume, br, jmp, trap;
    logic [31:0] bt, jt;
    logic [31:0] pc, pc_plus_inc, epc;
    logic        fetch_valid, misaligned;
    logic [1:0]  state;

    pc_unit dut (
        .i_clk           (clk),
        .i_reset         (rst),
        .i_stall         (stall),
        .i_halt          (halt),
        .i_resume        (resume),
        .i_branch_taken  (br),
        .i_branch_target (bt),
        .i_jump_en       (jmp),
        .i_jump_target   (jt),
        .i_trap          (trap),
        .o_pc            (pc),
        .o_pc_plus_inc   (pc_plus_inc),
        .o_epc           (epc),
        .o_fetch_valid   (fetch_valid),
        .o_misaligned    (misaligned),
        .o_state         (state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] epc;
        logic        fv;
        logic        mis;
        logic [1:0]  st;
        int          due;
    } exp_t;

    typedef struct {
        bit          stall;
        bit          halt;
        bit          resume;
        bit          br;
        logic [31:0] bt;
        bit          j;
        logic [31:0] jt;
        bit          trap;
    } stim_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state: st 0=boot, 1=run, 2=halt
    logic [31:0] m_pc, m_epc;
    int          m_st;
    bit          m_mis;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '{default: '0};
        return s;
    endfunction

    task automatic model_reset();
        m_pc  = 32'h0;
        m_epc = 32'h0;
        m_st  = 0;
        m_mis = 1'b0;
    endtask

    task automatic model_step(input stim_t s);
        logic [31:0] t;
        m_mis = 1'b0;
        if (m_st == 0) begin
            m_st = 1;
        end else if (m_st == 1) begin
            if (s.trap) begin
                m_epc = m_pc;
                m_pc  = TRAP;
            end else if (s.j || s.br) begin
                t = s.j ? (s.jt - (s.jt % 2)) : s.bt;
                if (t % 4 != 0) begin
                    m_epc = t;
                    m_pc  = TRAP;
                    m_mis = 1'b1;
                end else begin
                    m_pc = t;
                end
            end else if (s.halt) begin
                m_st = 2;
            end else if (!s.stall) begin
                m_pc = m_pc + 32'd4;
            end
        end else begin
            if (s.trap) begin
                m_epc = m_pc;
                m_pc  = TRAP;
                m_st  = 1;
            end else if (s.resume) begin
                m_st = 1;
            end
        end
    endtask

    // Drive one cycle of inputs, predict the post-edge outputs, wait past the edge.
    task automatic step(input stim_t s);
        exp_t e;
        stall  = s.stall;
        halt   = s.halt;
        resume = s.resume;
        br     = s.br;
        bt     = s.bt;
        jmp    = s.j;
        jt     = s.jt;
        trap   = s.trap;
        model_step(s);
        e.pc  = m_pc;
        e.epc = m_epc;
        e.fv  = (m_st == 1);
        e.mis = m_mis;
        e.st  = 2'(m_st);
        e.due = cyc + 1;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset pulse between edges; called at posedge+1.
    task automatic mid_reset(input string tag);
        #2 rst = 1'b1;
        #1;
        chk({tag, "_pc"}, pc, 32'h0);
        chk({tag, "_state"}, 32'(state), 32'h0);
        chk({tag, "_fv"}, 32'(fetch_valid), 32'h0);
        chk({tag, "_mis"}, 32'(misaligned), 32'h0);
        chk({tag, "_epc"}, epc, 32'h0);
        q.delete();
        model_reset();
        #3 rst = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        while (q.size() > 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            if (e.due == cyc) begin
                chk("sb_pc", pc, e.pc);
                chk("sb_pc_plus_inc", pc_plus_inc, e.pc + 32'd4);
                chk("sb_epc", epc, e.epc);
                chk("sb_fetch_valid", 32'(fetch_valid), 32'(e.fv));
                chk("sb_misaligned", 32'(misaligned), 32'(e.mis));
                chk("sb_state", 32'(state), 32'(e.st));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        stim_t s;
        rst = 1'b1;
        stall = 0; halt = 0; resume = 0; br = 0; jmp = 0; trap = 0;
        bt = '0; jt = '0;
        model_reset();
        #7 rst = 1'b0;
        chk("reset_pc", pc, 32'h0);
        chk("reset_fv", 32'(fetch_valid), 32'h0);
        chk("reset_state", 32'(state), 32'h0);
        chk("reset_epc", epc, 32'h0);

        step(idle());
        chk("boot_run_pc", pc, 32'h0);
        chk("boot_run_fv", 32'(fetch_valid), 32'h1);
        step(idle());
        chk("first_inc", pc, 32'h4);
        step(idle());

        s = idle(); s.stall = 1;
        step(s);
        chk("stall1", pc, 32'h8);
        step(s);
        chk("stall2", pc, 32'h8);
        step(idle());
        chk("after_stall", pc, 32'hC);

        s = idle(); s.br = 1; s.bt = 32'h40;
        step(s);
        chk("branch_40", pc, 32'h40);
        s = idle(); s.j = 1; s.jt = 32'h81; s.br = 1; s.bt = 32'h200;
        step(s);
        chk("jump_wins", pc, 32'h80);

        s = idle(); s.br = 1; s.bt = 32'h1002;
        step(s);
        chk("mis_pc", pc, 32'h100);
        chk("mis_epc", epc, 32'h1002);
        chk("mis_pulse", 32'(misaligned), 32'h1);
        step(idle());
        chk("mis_clear", 32'(misaligned), 32'h0);

        s = idle(); s.br = 1; s.bt = 32'h24;
        step(s);
        s = idle(); s.trap = 1; s.stall = 1;
        step(s);
        chk("trap_pc", pc, 32'h100);
        chk("trap_epc", epc, 32'h24);

        s = idle(); s.halt = 1;
        step(s);
        chk("halt_fv", 32'(fetch_valid), 32'h0);
        step(idle());
        chk("halt_frozen", pc, 32'h100);
        s = idle(); s.resume = 1; s.trap = 1;
        step(s);
        chk("halt_trap_state", 32'(state), 32'h1);
        chk("halt_trap_pc", pc, 32'h100);

        s = idle(); s.halt = 1;
        step(s);
        mid_reset("reset_in_halt");

        step(idle());
        s = idle(); s.br = 1; s.bt = 32'hFFFF_FFFC;
        step(s);
        chk("wrap_link", pc_plus_inc, 32'h0);
        step(idle());
        chk("wrap_pc", pc, 32'h0);

        for (int i = 0; i < 3000; i++) begin
            s.stall  = ($urandom_range(0, 3) == 0);
            s.halt   = ($urandom_range(0, 15) == 0);
            s.resume = ($urandom_range(0, 2) == 0);
            s.br     = ($urandom_range(0, 5) == 0);
            s.bt     = $urandom() & (($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
            s.j      = ($urandom_range(0, 7) == 0);
            s.jt     = $urandom() & (($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFD);
            s.trap   = ($urandom_range(0, 19) == 0);
            step(s);
            if (i % 700 == 699) mid_reset("rand_reset");
        end

        step(idle());
        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_drain: got %0d pending expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised successor to the plain PC register.
- Holds the fetch PC and computes the next PC internally: sequential increment, branch/jump redirect, trap vectoring, stall and halt.
- Flags misaligned redirect targets and captures the exception PC.
- Sits between the branch/jump resolution logic and instruction memory in the single-cycle/early-pipeline datapath.

Parameters:
- DATA_WIDTH, `DATA_WIDTH (32): width of all address ports.
- RESET_ADDR, 32'h0000_0000: PC value loaded on reset.
- TRAP_ADDR, 32'h0000_0100: vector taken on trap or misaligned target.
- INC, 4: sequential increment in bytes.
- ALIGN_BITS, 2: target low bits that must be zero (2 for RV32I without C).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- stall  in  1  hold PC this cycle.
- halt  in  1  enter HALT state (e.g. ecall/ebreak stop).
- resume  in  1  leave HALT state.
- branch_taken  in  1  conditional branch resolved taken.
- branch_target  in  DATA_WIDTH  branch destination.
- jump_en  in  1  jal/jalr redirect.
- jump_target  in  DATA_WIDTH  jump destination; bit 0 is cleared internally (jalr rule).
- trap  in  1  external/illegal-instruction trap request.
- pc  out  DATA_WIDTH  current fetch address.
- pc_plus_inc  out  DATA_WIDTH  pc + INC (link value, combinational from pc).
- epc  out  DATA_WIDTH  PC captured at the last trap or misaligned redirect.
- fetch_valid  out  1  pc is a valid fetch this cycle.
- misaligned  out  1  one-cycle pulse: the last redirect target was misaligned.
- state_o  out  2  current FSM state, for debug.

Behaviour:
- Reset (async, any time, including mid-halt or mid-redirect):
  - pc=RESET_ADDR, epc=0, fetch_valid=0, misaligned=0, state=BOOT.
- FSM:
  - BOOT(00): one cycle with fetch_valid=0 and pc held; next cycle goes to RUN unconditionally. Inputs are ignored in BOOT.
  - RUN(01): fetch_valid=1 and pc updates per the priority list below.
  - HALT(10): fetch_valid=0 and pc held. When resume=1, go to RUN next cycle with pc unchanged. trap in HALT also goes to RUN with the trap redirect; trap wins over resume.
- RUN next-PC priority (highest first):
  - trap: pc<=TRAP_ADDR, epc<=pc.
  - jump_en: target=jump_target & ~1.
  - branch_taken: target=branch_target.
  - halt: state<=HALT, pc held.
  - stall: pc held.
  - otherwise: pc<=pc+INC, truncated to DATA_WIDTH, wrapping from all-ones region to low addresses silently.
- Redirect vs stall:
  - A redirect (trap/jump/branch) overrides stall. A resolved redirect must not be lost.
- Misaligned check on the jump/branch target:
  - Condition: target[ALIGN_BITS-1:0]!=0.
  - Action: pc<=TRAP_ADDR, epc<=target, misaligned=1 for exactly the following cycle.
  - Trap redirects are never checked.
- Simultaneous jump_en and branch_taken: jump wins.
- halt asserted together with a redirect: the redirect is taken and halt is ignored that cycle.
- Latency:
  - Every pc update is visible one cycle after the controlling inputs are sampled.
  - pc_plus_inc follows pc combinationally.
- epc holds its value until the next trap or misaligned event.

Decomposition:
- Add to defs.vh:
  - `PC_RESET_ADDR and `PC_TRAP_ADDR (defaults for the parameters).
  - FSM encodings `PC_ST_BOOT/RUN/HALT.
- Sub-module pc_next_sel (combinational):
  - Does the priority mux, bit-0 clear and misalignment detect.
  - Outputs next_pc, load_epc, epc_val and mis_flag.
- pc_unit keeps the FSM, the pc/epc/misaligned registers and the incrementer.

Test Plan:
- Reset then release: assert reset for 7 ns, release, clock 3 edges -> BOOT with pc=0, fetch_valid=0; then RUN with pc=0, fetch_valid=1; next edge pc=4.
- Sequential plus stall: from pc=8, stall high for 2 cycles, then release -> pc stays 8 for 2 cycles, then 0xC.
- Redirects: branch_taken with target 0x40 -> pc=0x40. Then jump_en with target 0x81, asserted together with branch_taken target 0x200 -> pc=0x80, jump wins and bit 0 is cleared.
- Misalignment: branch_target=0x1002 -> pc=0x100, epc=0x1002, misaligned=1 for one cycle then 0.
- Trap and halt:
  - trap at pc=0x24 while stall=1 -> pc=0x100, epc=0x24.
  - halt -> fetch_valid=0, pc frozen.
  - resume and trap together in HALT -> RUN, pc=0x100.
- Async reset mid-HALT and wrap:
  - Reset asserted between clock edges -> pc=0 and state=BOOT immediately, without waiting for an edge.
  - Separately, load pc=0xFFFF_FFFC via branch -> next pc=0x0000_0000.
